// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone = 2'd0,
    ParOdd  = 2'd1,
    ParEven = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  // Widest supported payload; narrower configurations zero-extend into this.
  localparam int unsigned MaxDataBits = 9;

  typedef struct packed {
    logic                   parity_err;
    logic                   frame_err;
    logic [MaxDataBits-1:0] data;
  } rx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped and flagged on 'drop'.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);
  assign count = count_q;
  // Head is forced to zero while empty so stale or unwritten storage never leaks out.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Qualify requests: pop needs data, push needs room or a simultaneous pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is gated by 'empty'.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority voting, error flags and
// a small receive FIFO behind a valid/ready handshake.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uartrx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int unsigned Div  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam int unsigned ScW  = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
  localparam logic [ScW-1:0]  ScLo    = ScW'(OVERSAMPLE / 2 - 1);
  localparam logic [ScW-1:0]  ScMid   = ScW'(OVERSAMPLE / 2);
  localparam logic [ScW-1:0]  ScHi    = ScW'(OVERSAMPLE / 2 + 1);
  localparam logic [ScW-1:0]  ScLast  = ScW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam parity_e         ParMode  = parity_e'(PARITY[1:0]);

  if (Div < 2) begin : g_div_chk
    $error("uart_rx_param: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE > 32) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
    $error("uart_rx_param: OVERSAMPLE must be even and within 8..32");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > MaxDataBits)) begin : g_db_chk
    $error("uart_rx_param: DATA_BITS must be within 5..9");
  end
  if (PARITY > 2) begin : g_par_chk
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  // Synchroniser and edge history
  logic sync1_q, s, s_prev_q;

  // Bit timing
  logic [CntW-1:0] div_cnt_q;
  logic            tick, mid, wrap, m, start_det;

  // Frame state
  rx_state_e          state_q, state_d;
  logic [ScW-1:0]     sc_q, sc_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic               par_err_q, par_err_d;
  logic               frame_err_q, frame_err_d;
  logic               par_bit_q, par_bit_d;
  logic               stop_idx_q, stop_idx_d;
  logic               samp_lo_q, samp_lo_d;
  logic               samp_mid_q, samp_mid_d;
  logic               done_q, done_d;
  logic               break_q, break_d;

  // FIFO plumbing
  logic [DATA_BITS+1:0] fifo_wdata, fifo_rdata;
  logic                 fifo_empty, fifo_full;

  // Two-flop synchroniser plus previous-sample register; all idle high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      s        <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      sync1_q  <= uartrx;
      s        <= sync1_q;
      s_prev_q <= s;
    end
  end

  assign start_det = (state_q == StIdle) && !s && s_prev_q;
  assign tick      = (div_cnt_q == CntLast);
  assign mid       = tick && (sc_q == ScHi);
  assign wrap      = tick && (sc_q == ScLast);
  // Third vote is taken live on the mid tick itself.
  assign m         = majority3(samp_lo_q, samp_mid_q, s);

  // Oversample tick divider; restarts on the start edge to align sampling to the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (start_det || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + CntW'(1);
    end
  end

  // Receive FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sc_q        <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_idx_q  <= 1'b0;
      samp_lo_q   <= 1'b1;
      samp_mid_q  <= 1'b1;
      done_q      <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      par_bit_q   <= par_bit_d;
      stop_idx_q  <= stop_idx_d;
      samp_lo_q   <= samp_lo_d;
      samp_mid_q  <= samp_mid_d;
      done_q      <= done_d;
      break_q     <= break_d;
    end
  end

  // Next-state: sample counting, voting and per-state frame handling.
  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    idx_d       = idx_q;
    data_d      = data_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    par_bit_d   = par_bit_q;
    stop_idx_d  = stop_idx_q;
    samp_lo_d   = samp_lo_q;
    samp_mid_d  = samp_mid_q;
    done_d      = 1'b0;
    break_d     = 1'b0;

    if (tick) begin
      sc_d = (sc_q == ScLast) ? '0 : sc_q + ScW'(1);
      if (sc_q == ScLo)  samp_lo_d  = s;
      if (sc_q == ScMid) samp_mid_d = s;
    end

    unique case (state_q)
      StIdle: begin
        if (start_det) begin
          state_d     = StStart;
          sc_d        = '0;
          data_d      = '0;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
          par_bit_d   = 1'b0;
          stop_idx_d  = 1'b0;
        end
      end
      StStart: begin
        if (mid && m) begin
          state_d = StIdle;  // glitch shorter than half a bit
        end else if (wrap) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (mid) data_d[idx_q] = m;
        if (wrap) begin
          if (idx_q == IdxLast) begin
            state_d = (ParMode != ParNone) ? StParity : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (mid) begin
          par_bit_d = m;
          par_err_d = ((^data_q) ^ m) != (ParMode == ParOdd);
        end
        if (wrap) state_d = StStop;
      end
      StStop: begin
        if (mid) begin
          frame_err_d = frame_err_q | ~m;
          if (stop_idx_q == StopLast) begin
            // Finish on the mid tick so the next start edge has half a bit of margin.
            done_d  = 1'b1;
            break_d = frame_err_d && (data_q == '0) &&
                      ((ParMode == ParNone) || !par_bit_q);
            state_d = m ? StIdle : StWaitHigh;
          end
        end else if (wrap) begin
          stop_idx_d = 1'b1;
        end
      end
      StWaitHigh: begin
        if (s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fifo_wdata = {par_err_q, frame_err_q, data_q};

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done_q),
    .wdata (fifo_wdata),
    .pop   (rx_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count),
    .drop  (overrun)
  );

  assign {rx_parity_err, rx_frame_err, rx_data} = fifo_rdata;
  assign rx_valid  = !fifo_empty;
  assign break_det = break_q;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, oversampling UART receiver. Successor to the fixed 8N1/115200 receiver.
- Adds configurable baud, oversampling, data width, parity and stop bits.
- Adds 3-sample majority voting, error flags (frame, parity, break, overrun) and a small receive FIFO behind a valid/ready handshake.
- Sits between the board RX pin and the command/echo logic; feeds the tx-with-buffer path.

Parameters:
- CLK_HZ, 100000000: system clock frequency.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit. Even, 8..32.
- DATA_BITS, 8: payload bits, 5..9, LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 8: entries. Power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- uartrx  in  1  raw asynchronous serial input (idle high).
- rx_data  out  DATA_BITS  head-of-FIFO payload.
- rx_frame_err  out  1  head entry had a bad stop bit.
- rx_parity_err  out  1  head entry failed parity (0 when PARITY=0).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts head entry when rx_valid&rx_ready.
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full.
- break_det  out  1  one-cycle pulse: break condition detected.

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; FIFO empty.
  - All outputs 0; rx_data 0.
  - Synchroniser flops and previous-sample reg set to 1.
- Input sync: 2-flop synchroniser on uartrx. All decisions use the synchronised bit `s`.
- Tick gen: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation; elaboration error if DIV<2.
  - Counter runs 0..DIV-1; tick when count==DIV-1.
  - Counter is zeroed on start-edge detection.
- Sample counter `sc` runs 0..OVERSAMPLE-1 per bit and advances on tick.
  - Majority of s at sc = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 gives bit value `m`.
  - m is valid on the tick with sc==OVERSAMPLE/2+1 ("mid").
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: s==0 with previous s==1 → START, sc=0.
  - START at mid: m==1 → IDLE (glitch, nothing pushed). Else continue; at sc wrap → DATA, bit index 0.
  - DATA: at mid, shift m into bit[idx]. At wrap, idx==DATA_BITS-1 → PARITY if PARITY≠0, else STOP; otherwise idx+1.
  - PARITY: at mid, parity_err = (XOR of data ^ m) != (PARITY==1). At wrap → STOP.
  - STOP: at mid, frame_err |= !m.
    - Non-final stop bit: wait to wrap, then next stop bit.
    - Final stop bit: complete frame on this mid tick; next state IDLE if m==1, else WAIT_HIGH. Early return to IDLE gives half-bit resync margin.
  - WAIT_HIGH: stay until s==1, then IDLE. No start detection meanwhile.
- Completion, on the cycle after the final-stop mid tick:
  - Push {parity_err, frame_err, data} to the FIFO.
  - break_det pulses when frame_err && data==0 && (PARITY==0 || received parity bit==0). The break frame is still pushed.
- FIFO: show-ahead; rx_data, rx_frame_err, rx_parity_err reflect the head entry.
  - Pop on rx_valid&&rx_ready. rx_valid=1 the cycle after a push into an empty FIFO.
  - Push when full with no pop in the same cycle: new entry dropped, overrun pulses 1 cycle, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, no overrun, count unchanged.
  - Push and pop in the same cycle at count 1: head advances to the new entry, rx_valid stays 1.
  - Pointers wrap modulo FIFO_DEPTH. rx_ready while empty has no effect.
- Reset mid-frame: partial frame discarded, FIFO cleared, no pulse generated.
- Latency, 8N1/115200/100 MHz: about 9.5 bit times (~8208 clk) + 4 clk from start falling edge to rx_valid.

Decomposition:
- Package uart_pkg:
  - parity_e (NONE, ODD, EVEN).
  - rx_state_e.
  - rx_entry_t struct {parity_err, frame_err, data}, width from DATA_BITS via a parametrised typedef macro or the max-width 9.
  - Helper function majority3.
- Sub-module uart_rx_fifo: parametrised sync FIFO (WIDTH, DEPTH) with push/pop/full/empty/count and the same-cycle push/pop rules above. Reusable later by the tx-with-buffer path.

Test Plan:
- Default params; send 0xA5 and 0x3C back-to-back, rx_ready=1 → two rx_valid beats with data 0xA5, 0x3C, both error flags 0.
- Glitch: uartrx low for 300 clk (< half bit of 434) → no rx_valid, FSM returns to IDLE, next byte 0x55 received correctly.
- PARITY=2 (even), send 0x07 with parity bit 0 (wrong) → rx_data 0x07, rx_parity_err=1. Repeat with parity 1 → rx_parity_err=0.
- Stop bit forced 0 on byte 0x81 → rx_frame_err=1, data 0x81, no break_det. Line held low 2 frames with data 0x00 → break_det pulses once; one entry with frame_err pushed, then WAIT_HIGH until the line releases.
- FIFO_DEPTH=4, rx_ready=0, send 5 bytes 0x01..0x05 → rx_count=4, overrun pulses once on byte 5. Then drain → 0x01..0x04 in order, rx_valid drops after the 4th pop.
- Async reset asserted mid-data of byte 0xF0 → all outputs 0 immediately, rx_count 0. Next byte 0x12 after release is received correctly.
